// File: rtl/div_seq.sv
// Sequencer around an external 32-bit unsigned divider: extends and takes the
// magnitude of byte/word operands, then restores signs and checks quotient range.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        size,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        div_err,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic        div_valid,
  input  logic        div_dbz,
  input  logic [31:0] div_val,
  input  logic [31:0] div_rem
);

  typedef enum logic [2:0] {IDLE, PREP, START, WAIT, FIX, DONE} state_t;

  state_t      state;
  logic        size_r, sgn_r;
  logic [31:0] dvd_r;
  logic [15:0] dvs_r;
  logic        neg_a, neg_b;
  logic [31:0] q_r, r_r;
  logic        err_r;

  logic [31:0] dvd_x, a_mag;
  logic [15:0] dvs_x, b_mag;
  logic        a_neg, b_neg;

  // Byte operands are widened to word semantics so the rest of the path is uniform.
  always_comb begin
    dvd_x = size_r ? dvd_r : {{16{sgn_r & dvd_r[15]}}, dvd_r[15:0]};
    dvs_x = size_r ? dvs_r : {{8{sgn_r & dvs_r[7]}}, dvs_r[7:0]};
    a_neg = sgn_r & dvd_x[31];
    b_neg = sgn_r & dvs_x[15];
    a_mag = a_neg ? -dvd_x : dvd_x;
    b_mag = b_neg ? -dvs_x : dvs_x;
  end

  logic        neg_q, ovf;
  logic [31:0] q_lim, q_s, r_s;
  logic [15:0] quot_n, rem_n;

  // A negative quotient may reach one step further than a positive one.
  always_comb begin
    neg_q = neg_a ^ neg_b;
    if (!sgn_r)     q_lim = size_r ? 32'h0000_FFFF : 32'h0000_00FF;
    else if (neg_q) q_lim = size_r ? 32'h0000_8000 : 32'h0000_0080;
    else            q_lim = size_r ? 32'h0000_7FFF : 32'h0000_007F;
    ovf    = q_r > q_lim;
    q_s    = neg_q ? -q_r : q_r;
    r_s    = neg_a ? -r_r : r_r;
    quot_n = size_r ? q_s[15:0] : {8'h00, q_s[7:0]};
    rem_n  = size_r ? r_s[15:0] : {8'h00, r_s[7:0]};
  end

  wire unused = &{1'b0, q_s[31:16], r_s[31:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quot      <= 16'h0;
      rem       <= 16'h0;
      div_err   <= 1'b0;
      div_start <= 1'b0;
      div_a     <= 32'h0;
      div_b     <= 32'h0;
      size_r    <= 1'b0;
      sgn_r     <= 1'b0;
      dvd_r     <= 32'h0;
      dvs_r     <= 16'h0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      q_r       <= 32'h0;
      r_r       <= 32'h0;
      err_r     <= 1'b0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            size_r <= size;
            sgn_r  <= signed_op;
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          neg_a <= a_neg;
          neg_b <= b_neg;
          if (dvs_x == 16'h0) begin
            quot    <= 16'h0;
            rem     <= 16'h0;
            div_err <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            div_a     <= a_mag;
            div_b     <= {16'h0, b_mag};
            div_start <= 1'b1;
            state     <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            q_r   <= div_val;
            r_r   <= div_rem;
            err_r <= div_dbz | ~div_valid;
            state <= FIX;
          end
        end
        FIX: begin
          div_err <= err_r | ovf;
          quot    <= (err_r | ovf) ? 16'h0 : quot_n;
          rem     <= (err_r | ovf) ? 16'h0 : rem_n;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq with a behavioural divider and an integer-arithmetic reference.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        size = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = 32'h0;
  logic [15:0] divisor = 16'h0;
  logic        busy, done, div_err, div_start;
  logic [15:0] quot, rem;
  logic [31:0] div_a, div_b;
  logic        div_done = 1'b0;
  logic        div_valid = 1'b1;
  logic        div_dbz = 1'b0;
  logic [31:0] div_val = 32'h0;
  logic [31:0] div_rem = 32'h0;

  div_seq dut (
    .clk(clk), .rst(rst), .req(req), .size(size), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quot(quot), .rem(rem), .div_err(div_err), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_valid(div_valid),
    .div_dbz(div_dbz), .div_val(div_val), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int start_cnt = 0;
  int dd_cyc = 0;
  int force_lat = -1;
  int m_lat = 0;
  bit m_busy = 0;
  bit inj_inv = 0;
  logic [31:0] ma = 32'h0, mb = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) start_cnt <= start_cnt + 1;
  end

  // External divider: variable latency, spurious completion pulses whenever it has no job.
  always @(negedge clk) begin
    div_done  = 1'b0;
    div_valid = 1'b1;
    div_dbz   = 1'b0;
    if (!busy) m_busy = 0;
    if (div_start) begin
      ma = div_a;
      mb = div_b;
      m_busy = 1;
      m_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
    end else if (m_busy) begin
      if (m_lat == 0) begin
        chk("div_a_stable", div_a, ma);
        chk("div_b_stable", div_b, mb);
        div_done  = 1'b1;
        div_dbz   = (mb == 0);
        div_val   = (mb == 0) ? 32'h0 : ma / mb;
        div_rem   = (mb == 0) ? 32'h0 : ma % mb;
        div_valid = !inj_inv;
        dd_cyc    = cyc;
        m_busy    = 0;
      end else m_lat--;
    end else if ($urandom_range(0, 3) == 0) begin
      div_done  = 1'b1;
      div_val   = $urandom;
      div_rem   = $urandom;
      div_valid = 1'($urandom_range(0, 1));
      div_dbz   = 1'($urandom_range(0, 1));
    end
  end

  // Reference: signed/unsigned integer division, truncating toward zero.
  function automatic void ref_div(input logic sz, input logic sg, input logic [31:0] a,
                                  input logic [15:0] b, output logic err,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic [31:0] am, output logic [31:0] bm);
    longint A, B, Q, R, lo, hi, mask;
    int n;
    n = sz ? 16 : 8;
    if (sg) begin
      A = sz ? longint'($signed(a)) : longint'($signed(a[15:0]));
      B = sz ? longint'($signed(b)) : longint'($signed(b[7:0]));
    end else begin
      A = sz ? longint'(a) : longint'(a[15:0]);
      B = sz ? longint'(b) : longint'(b[7:0]);
    end
    am = 32'((A < 0) ? -A : A);
    bm = 32'((B < 0) ? -B : B);
    mask = (longint'(1) << n) - 1;
    lo = sg ? -(longint'(1) << (n - 1)) : 0;
    hi = sg ? (longint'(1) << (n - 1)) - 1 : mask;
    err = 1'b1; q = 16'h0; r = 16'h0;
    if (B != 0) begin
      Q = A / B;
      R = A % B;
      if (Q >= lo && Q <= hi) begin
        err = 1'b0;
        q = 16'(Q & mask);
        r = 16'(R & mask);
      end
    end
  endfunction

  task automatic run_op(input logic sz, input logic sg, input logic [31:0] a,
                        input logic [15:0] b, input bit inv, input bit noise);
    logic e_err;
    logic [15:0] e_q, e_r;
    logic [31:0] e_am, e_bm;
    int n0, s0, k;
    ref_div(sz, sg, a, b, e_err, e_q, e_r, e_am, e_bm);
    if (inv && e_bm != 0) begin e_err = 1'b1; e_q = 16'h0; e_r = 16'h0; end
    inj_inv = inv;
    size = sz; signed_op = sg; dividend = a; divisor = b; req = 1'b1;
    n0 = cyc; s0 = start_cnt;
    @(negedge clk);
    req = 1'b0;
    chk("busy_prep", 32'(busy), 1);
    k = 0;
    while (!done && k < 64) begin
      if (noise) begin
        req = 1'($urandom_range(0, 1));
        dividend = $urandom; divisor = 16'($urandom);
        size = 1'($urandom_range(0, 1)); signed_op = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      k++;
    end
    req = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    else begin
      if (e_bm == 0) begin
        chk("lat_zero_div", 32'(cyc - n0), 2);
        chk("no_start", 32'(start_cnt - s0), 0);
      end else begin
        chk("lat_div_done", 32'(cyc - dd_cyc), 2);
        chk("one_start", 32'(start_cnt - s0), 1);
        chk("div_a_mag", ma, e_am);
        chk("div_b_mag", mb, e_bm);
      end
      chk("quot", 32'(quot), 32'(e_q));
      chk("rem", 32'(rem), 32'(e_r));
      chk("div_err", 32'(div_err), 32'(e_err));
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, div_err, div_start}), 0);
    chk({tag, "_quot"}, 32'(quot), 0);
    chk({tag, "_rem"}, 32'(rem), 0);
    chk({tag, "_div_a"}, div_a, 0);
    chk({tag, "_div_b"}, div_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd;
    logic sz, sg;
    logic [31:0] a;
    logic [15:0] b;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b0;

    // Directed vectors
    run_op(1, 0, 32'd100000, 16'd7, 0, 0);
    chk("v036_quot", 32'(quot), 14285);
    chk("v036_rem", 32'(rem), 5);
    run_op(0, 1, 32'h0000_FFF9, 16'h0002, 0, 0);
    chk("v037_quot", 32'(quot), 32'h00FD);
    chk("v037_rem", 32'(rem), 32'h00FF);
    run_op(0, 0, 32'h0000_1234, 16'h0000, 0, 0);
    run_op(1, 1, 32'h8765_4321, 16'h0000, 0, 0);
    run_op(0, 1, 32'h0000_0055, 16'hFF00, 0, 0);
    run_op(0, 0, 32'h0000_0400, 16'h0002, 0, 0);
    chk("v039a_err", 32'(div_err), 1);
    run_op(1, 1, 32'hFFFF_0000, 16'h0002, 0, 0);
    chk("v039b_quot", 32'(quot), 32'h8000);
    chk("v039b_err", 32'(div_err), 0);
    run_op(1, 1, 32'h0001_0000, 16'h0002, 0, 0);
    chk("v039c_err", 32'(div_err), 1);
    run_op(1, 1, 32'h8000_0000, 16'hFFFF, 0, 0);
    run_op(1, 1, 32'h8000_0000, 16'h8000, 0, 0);
    run_op(0, 1, 32'h0000_0080, 16'h00FF, 0, 0);
    run_op(1, 0, 32'd1000, 16'd10, 1, 0);

    // Reset while waiting on the divider
    force_lat = 30;
    size = 1'b1; signed_op = 1'b0; dividend = 32'd5000; divisor = 16'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outs("rst_wait");
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("no_done_after_rst", 32'(nd), 0);
    force_lat = -1;
    run_op(0, 0, 32'h0000_0064, 16'h000A, 0, 0);
    chk("v040_quot", 32'(quot), 32'h000A);
    chk("v040_rem", 32'(rem), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(1, 1, 32'hFFFF_FF9C, 16'h0007, 0, 0);

    // req held high: the second operation is taken on the first IDLE cycle
    size = 1'b1; signed_op = 1'b0; dividend = 32'd100000; divisor = 16'd7; req = 1'b1;
    @(negedge clk);
    dividend = 32'hDEAD_BEEF; divisor = 16'h0001;
    k = 0;
    while (!done && k < 64) begin @(negedge clk); k++; end
    chk("held1_done", 32'(done), 1);
    chk("held1_quot", 32'(quot), 14285);
    dividend = 32'd1000; divisor = 16'd10;
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 0);
    @(negedge clk);
    chk("held_restart", 32'(busy), 1);
    req = 1'b0;
    k = 0;
    while (!done && k < 64) begin @(negedge clk); k++; end
    chk("held2_done", 32'(done), 1);
    chk("held2_quot", 32'(quot), 100);
    chk("held2_rem", 32'(rem), 0);
    repeat (2) @(negedge clk);
    chk("held_stop", 32'(busy), 0);

    // Randomized operations, with req/operand noise while busy
    repeat (250) begin
      sz = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0;
        1: a = a >> $urandom_range(8, 30);
        2: b = 16'hFFFF;
        3: a = 32'h8000_0000;
        4: begin a = a >> 20; b = b >> $urandom_range(0, 12); end
        default: ;
      endcase
      run_op(sz, sg, a, b, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
